maxnet_host_if: RTL and testbench

MAXNET_HOST_IF -- requirements
Module: maxnet_host_if

---
 rtl/maxnet_host_if.sv | 151 +++++++++++++++
 tb/tb_maxnet_host_if.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_host_if.sv
// Host-side sequencer for a 4-input Maxnet datapath: collects four samples, loads them,
// waits for the datapath to finish, then hands the winner downstream. Option: MAXNET_TIMEOUT_EN.
module maxnet_host_if #(
   parameter int                 WIDTH   = 5,
   parameter logic [WIDTH-1:0]   W_INH   = WIDTH'(5'b11110),
   parameter logic [WIDTH-1:0]   W_SELF  = WIDTH'(5'b01000),
   parameter int                 TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] x1,
   output logic [WIDTH-1:0] x2,
   output logic [WIDTH-1:0] x3,
   output logic [WIDTH-1:0] x4,
   output logic [WIDTH-1:0] w1,
   output logic [WIDTH-1:0] w2,
   output logic             ld,
   output logic             sel,
   input  logic             done,
   input  logic [WIDTH-1:0] max,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_err,
   input  logic             res_ready
);

   typedef enum logic [2:0] {
      COLLECT,
      LOAD,
      RUN,
      SETTLE,
      RESULT
   } state_t;

   state_t           state_q;
   logic [1:0]       idx_q;
   logic [1:0]       idx_d;
   logic [WIDTH-1:0] x_q [4];
   logic             ld_q;
   logic             sel_q;
   logic             res_valid_q;
   logic [WIDTH-1:0] res_data_q;
   logic             accept;

   always_comb begin
      accept = in_valid && (state_q == COLLECT);
      idx_d  = idx_q + 2'd1;
   end

`ifdef MAXNET_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic          res_err_q;
   logic          timeout;

   assign timeout = (cnt_q == CW'(TIMEOUT - 1));
   assign res_err = res_err_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT > 0);
   assign res_err        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         for (int unsigned i = 0; i < 4; i++) x_q[i] <= '0;
         ld_q        <= 1'b0;
         sel_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
`ifdef MAXNET_TIMEOUT_EN
         cnt_q       <= '0;
         res_err_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            COLLECT: begin
               if (accept) begin
                  x_q[idx_q] <= in_data;
                  // idx wraps 3 -> 0 on the fourth beat, leaving it cleared for the next set
                  idx_q      <= idx_d;
                  if (idx_q == 2'd3) begin
                     state_q <= LOAD;
                     ld_q    <= 1'b1;
                  end
               end
            end
            LOAD: begin
               ld_q    <= 1'b0;
               sel_q   <= 1'b1;
               state_q <= RUN;
`ifdef MAXNET_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            RUN: begin
               if (done) begin
                  sel_q   <= 1'b0;
                  state_q <= SETTLE;
`ifdef MAXNET_TIMEOUT_EN
               end else if (timeout) begin
                  sel_q       <= 1'b0;
                  res_data_q  <= '0;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  state_q     <= RESULT;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
`endif
               end
            end
            SETTLE: begin
               // datapath max register lags done by one cycle, so sample it here
               res_data_q  <= max;
               res_valid_q <= 1'b1;
               state_q     <= RESULT;
`ifdef MAXNET_TIMEOUT_EN
               res_err_q   <= 1'b0;
`endif
            end
            RESULT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= COLLECT;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign in_ready  = (state_q == COLLECT);
   assign x1        = x_q[0];
   assign x2        = x_q[1];
   assign x3        = x_q[2];
   assign x4        = x_q[3];
   assign w1        = W_INH;
   assign w2        = W_SELF;
   assign ld        = ld_q;
   assign sel       = sel_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_maxnet_host_if.sv
// Directed and randomized bench for maxnet_host_if; expected results come from a
// sample-list model (winner = arithmetic maximum of the four accepted samples).
module tb_maxnet_host_if;

   localparam int WIDTH = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready;
   logic [WIDTH-1:0] x1, x2, x3, x4, w1, w2;
   logic             ld, sel;
   logic             done = 1'b0;
   logic [WIDTH-1:0] max = '0;
   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic             res_err;
   logic             res_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] smp [4];
   int               gap [4];

   maxnet_host_if #(.WIDTH(WIDTH), .W_INH(5'b11110), .W_SELF(5'b01000), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .x1(x1), .x2(x2), .x3(x3), .x4(x4), .w1(w1), .w2(w2), .ld(ld), .sel(sel),
      .done(done), .max(max), .res_valid(res_valid), .res_data(res_data),
      .res_err(res_err), .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] slot(input int i);
      case (i)
         0:       return x1;
         1:       return x2;
         2:       return x3;
         default: return x4;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] winner();
      logic [WIDTH-1:0] m = '0;
      for (int i = 0; i < 4; i++) if (smp[i] > m) m = smp[i];
      return m;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_x1"}, 32'(x1), 32'h0);
      chk({tag, "_x2"}, 32'(x2), 32'h0);
      chk({tag, "_x3"}, 32'(x3), 32'h0);
      chk({tag, "_x4"}, 32'(x4), 32'h0);
      chk({tag, "_ld"}, 32'(ld), 32'h0);
      chk({tag, "_sel"}, 32'(sel), 32'h0);
      chk({tag, "_rvalid"}, 32'(res_valid), 32'h0);
      chk({tag, "_rdata"}, 32'(res_data), 32'h0);
      chk({tag, "_rerr"}, 32'(res_err), 32'h0);
      chk({tag, "_inready"}, 32'(in_ready), 32'h1);
   endtask

   task automatic chk_samples(input string tag);
      for (int i = 0; i < 4; i++) chk(tag, 32'(slot(i)), 32'(smp[i]));
   endtask

   // Feeds smp[] with gap[] idle cycles before each beat; ends with the DUT in LOAD.
   task automatic collect();
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap[i]; g++) begin
            in_valid  = 1'b0;
            in_data   = WIDTH'($urandom);
            done      = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            tick();
            chk("gap_inready", 32'(in_ready), 32'h1);
            chk("gap_noload", 32'(ld), 32'h0);
            chk("gap_nores", 32'(res_valid), 32'h0);
         end
         done      = 1'b0;
         res_ready = 1'b0;
         in_valid  = 1'b1;
         in_data   = smp[i];
         tick();
         in_valid = 1'b0;
         in_data  = WIDTH'($urandom);
         chk("beat_slot", 32'(slot(i)), 32'(smp[i]));
         if (i < 3) begin
            chk("beat_inready", 32'(in_ready), 32'h1);
            chk("beat_noload", 32'(ld), 32'h0);
         end
      end
      chk("load_ld", 32'(ld), 32'h1);
      chk("load_sel", 32'(sel), 32'h0);
      chk("load_inready", 32'(in_ready), 32'h0);
      chk_samples("load_x");
   endtask

   // From LOAD: done after done_delay RUN cycles, result held for ready_delay cycles.
   task automatic finish_txn(input int done_delay, input int ready_delay);
      logic [WIDTH-1:0] m;
      m        = winner();
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      tick();
      chk("run_ld", 32'(ld), 32'h0);
      chk("run_sel", 32'(sel), 32'h1);
      chk("run_inready", 32'(in_ready), 32'h0);
      max = ~m;
      for (int c = 0; c < done_delay; c++) begin
         done    = 1'b0;
         in_data = WIDTH'($urandom);
         tick();
         chk("run_wait_sel", 32'(sel), 32'h1);
         chk("run_wait_nores", 32'(res_valid), 32'h0);
         chk_samples("run_stable_x");
      end
      done = 1'b1;
      tick();
      chk("settle_nores", 32'(res_valid), 32'h0);
      chk("settle_ld", 32'(ld), 32'h0);
      done = 1'($urandom_range(0, 1));
      max  = m;
      tick();
      chk("res_valid", 32'(res_valid), 32'h1);
      chk("res_data", 32'(res_data), 32'(m));
      chk("res_err", 32'(res_err), 32'h0);
      chk("res_ldsel", 32'({ld, sel}), 32'h0);
      max = ~m;
      for (int c = 0; c < ready_delay; c++) begin
         res_ready = 1'b0;
         in_data   = WIDTH'($urandom);
         done      = 1'($urandom_range(0, 1));
         tick();
         chk("bp_valid", 32'(res_valid), 32'h1);
         chk("bp_data", 32'(res_data), 32'(m));
         chk("bp_inready", 32'(in_ready), 32'h0);
      end
      res_ready = 1'b1;
      tick();
      chk("xfer_valid", 32'(res_valid), 32'h0);
      chk("xfer_inready", 32'(in_ready), 32'h1);
      res_ready = 1'b0;
      in_valid  = 1'b0;
      done      = 1'b0;
   endtask

   task automatic set_gaps(input int a, input int b, input int c, input int d);
      gap[0] = a; gap[1] = b; gap[2] = c; gap[3] = d;
   endtask

   task automatic rand_samples();
      for (int i = 0; i < 4; i++) smp[i] = WIDTH'($urandom);
   endtask

   initial begin
      // reset asserted with a sample already waiting
      in_valid = 1'b1;
      in_data  = 5'h11;
      #1 rst = 1'b0;
      #2;
      chk_reset_outputs("rst0");
      chk("w1", 32'(w1), 32'h1e);
      chk("w2", 32'(w2), 32'h08);
      #9 rst = 1'b1;
      tick();
      chk("first_edge_accept", 32'(x1), 32'h11);
      in_valid = 1'b0;

      // asynchronous reset mid-collect clears the partial sample immediately
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("rst_async");
      #2 rst = 1'b1;

      // directed 3,9,5,1 back-to-back; done 4 cycles after ld
      smp[0] = 5'd3; smp[1] = 5'd9; smp[2] = 5'd5; smp[3] = 5'd1;
      set_gaps(0, 0, 0, 0);
      collect();
      finish_txn(3, 0);

      // gapped beats on cycles 0,3,4,9 with 10 cycles of backpressure
      rand_samples();
      set_gaps(0, 2, 0, 4);
      collect();
      finish_txn(int'($urandom_range(0, 5)), 10);

      for (int t = 0; t < 8; t++) begin
         rand_samples();
         set_gaps(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         collect();
         finish_txn(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      end

      // reset mid-RUN
      rand_samples();
      set_gaps(0, 1, 0, 0);
      collect();
      tick();
      tick();
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("rst_run");
      rst = 1'b1;
      rand_samples();
      set_gaps(0, 0, 1, 0);
      collect();
      finish_txn(2, 1);

      // reset with two beats collected: next set starts at slot 0
      smp[0] = 5'h1a; smp[1] = 5'h1b;
      in_valid = 1'b1; in_data = smp[0]; tick();
      in_data = smp[1]; tick();
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("rst_partial");
      rst = 1'b1;
      rand_samples();
      set_gaps(1, 0, 0, 0);
      collect();
      finish_txn(1, 0);

      // reset while a result is pending discards it
      rand_samples();
      set_gaps(0, 0, 0, 0);
      collect();
      tick();
      done = 1'b1; tick();
      done = 1'b0; max = winner(); tick();
      chk("pend_valid", 32'(res_valid), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("rst_result");
      rst = 1'b1;

      // done never arrives
      rand_samples();
      set_gaps(0, 0, 0, 0);
      collect();
      tick();
      done = 1'b0;
`ifdef MAXNET_TIMEOUT_EN
      repeat (14) tick();
      chk("to_before", 32'(res_valid), 32'h0);
      tick();
      chk("to_valid", 32'(res_valid), 32'h1);
      chk("to_err", 32'(res_err), 32'h1);
      chk("to_data", 32'(res_data), 32'h0);
      chk("to_sel", 32'(sel), 32'h0);
      res_ready = 1'b1;
      tick();
      chk("to_xfer", 32'(res_valid), 32'h0);
      chk("to_inready", 32'(in_ready), 32'h1);
      res_ready = 1'b0;
`else
      repeat (40) tick();
      chk("hang_nores", 32'(res_valid), 32'h0);
      chk("hang_sel", 32'(sel), 32'h1);
      chk("hang_inready", 32'(in_ready), 32'h0);
      chk("hang_err", 32'(res_err), 32'h0);
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("rst_hang");
      rst = 1'b1;
`endif

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
